// File: rtl/stim_seq_if.sv
// Control/drive bundle for stim_seq: start/stop requests in, pattern drives and status out.
interface stim_seq_if;
  logic       start;
  logic       stop;
  logic       in1;
  logic       in2;
  logic       in3;
  logic       busy;
  logic       done;
  logic [1:0] step;

  modport master (
    output start, stop,
    input  in1, in2, in3, busy, done, step
  );

  modport slave (
    input  start, stop,
    output in1, in2, in3, busy, done, step
  );
endinterface

// File: rtl/stim_seq.sv
// Four-step stimulus sequencer: drives thermometer patterns 000,001,011,111 on {in3,in2,in1},
// each held for HOLD cycles, with abort, completion pulse and fully registered outputs.
module stim_seq #(
  parameter int unsigned HOLD = 20
) (
  input logic     clk,
  input logic     rst,
  stim_seq_if.slave bus
);

  localparam int unsigned CntW = ($clog2(HOLD + 1) < 1) ? 1 : $clog2(HOLD + 1);
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      next_step;

  assign next_step = bus.step + 2'd1;

  // Thermometer pattern: one more line asserted per step.
  function automatic logic [2:0] pat_of(input logic [1:0] s);
    case (s)
      2'd0:    pat_of = 3'b000;
      2'd1:    pat_of = 3'b001;
      2'd2:    pat_of = 3'b011;
      default: pat_of = 3'b111;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q                     <= StIdle;
      cnt_q                       <= '0;
      bus.step                    <= 2'd0;
      {bus.in3, bus.in2, bus.in1} <= 3'b000;
      bus.busy                    <= 1'b0;
      bus.done                    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start && !bus.stop) begin
            state_q                     <= StRun;
            cnt_q                       <= '0;
            bus.step                    <= 2'd0;
            {bus.in3, bus.in2, bus.in1} <= 3'b000;
            bus.busy                    <= 1'b1;
          end
        end
        StRun: begin
          // Abort wins over completion, so a stop on the last edge suppresses done.
          if (bus.stop) begin
            state_q                     <= StIdle;
            cnt_q                       <= '0;
            bus.step                    <= 2'd0;
            {bus.in3, bus.in2, bus.in1} <= 3'b000;
            bus.busy                    <= 1'b0;
          end else if (cnt_q == HoldLast) begin
            cnt_q <= '0;
            if (bus.step != 2'd3) begin
              bus.step                    <= next_step;
              {bus.in3, bus.in2, bus.in1} <= pat_of(next_step);
            end else begin
              state_q                     <= StIdle;
              bus.step                    <= 2'd0;
              {bus.in3, bus.in2, bus.in1} <= 3'b000;
              bus.busy                    <= 1'b0;
              bus.done                    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_stim_seq.sv
// Scoreboard bench for stim_seq: stimulus pushes the expected post-edge output word per cycle,
// per-DUT monitors pop and compare on the falling edge. Covers HOLD=4 and HOLD=1 instances.
module tb_stim_seq;

  logic clk = 1'b0;
  logic rst4;
  logic rst1;

  always #5 clk = ~clk;

  stim_seq_if if4 ();
  stim_seq_if if1 ();

  stim_seq #(.HOLD(4)) u_dut4 (.clk(clk), .rst(rst4), .bus(if4.slave));
  stim_seq #(.HOLD(1)) u_dut1 (.clk(clk), .rst(rst1), .bus(if1.slave));

  // Output word: {busy, done, step[1:0], in3, in2, in1}
  localparam logic [6:0] WIdle = 7'b00_00_000;
  localparam logic [6:0] WDone = 7'b01_00_000;

  logic [6:0] q4[$];
  logic [6:0] q1[$];
  int checks = 0;
  int passes = 0;
  int cyc4_n = 0;
  int cyc1_n = 0;

  // Hand-computed run-state words for steps 0..3.
  function automatic logic [6:0] run_w(input int s);
    logic [6:0] tbl [4];
    tbl[0] = 7'b10_00_000;
    tbl[1] = 7'b10_01_001;
    tbl[2] = 7'b10_10_011;
    tbl[3] = 7'b10_11_111;
    return tbl[s];
  endfunction

  task automatic cyc4(input logic st, input logic sp, input logic r, input logic [6:0] exp_w);
    if4.start = st;
    if4.stop  = sp;
    rst4      = r;
    @(posedge clk);
    #1;
    q4.push_back(exp_w);
  endtask

  task automatic cyc1(input logic st, input logic sp, input logic r, input logic [6:0] exp_w);
    if1.start = st;
    if1.stop  = sp;
    rst1      = r;
    @(posedge clk);
    #1;
    q1.push_back(exp_w);
  endtask

  // Starts a HOLD=4 sequence and runs its 16 busy cycles with start held at st_hold after
  // the first edge; the completion edge's outcome is left to the caller.
  task automatic run15_4(input logic st_hold);
    cyc4(1'b1, 1'b0, 1'b0, run_w(0));
    for (int i = 1; i < 16; i++) cyc4(st_hold, 1'b0, 1'b0, run_w(i / 4));
  endtask

  always @(negedge clk) begin
    logic [6:0] e;
    logic [6:0] a;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      a = {if4.busy, if4.done, if4.step, if4.in3, if4.in2, if4.in1};
      checks++;
      if (a !== e) $display("FAIL hold4 cycle %0d: got %b expected %b", cyc4_n, a, e);
      else passes++;
      cyc4_n++;
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      a = {if1.busy, if1.done, if1.step, if1.in3, if1.in2, if1.in1};
      checks++;
      if (a !== e) $display("FAIL hold1 cycle %0d: got %b expected %b", cyc1_n, a, e);
      else passes++;
      cyc1_n++;
    end
  end

  initial begin
    if1.start = 1'b0;
    if1.stop  = 1'b0;
    rst1      = 1'b1;

    // Reset, then one full sequence with start pulsed.
    cyc4(1'b0, 1'b0, 1'b1, WIdle);
    cyc4(1'b0, 1'b0, 1'b1, WIdle);
    run15_4(1'b0);
    cyc4(1'b0, 1'b0, 1'b0, WDone);
    cyc4(1'b0, 1'b0, 1'b0, WIdle);
    cyc4(1'b0, 1'b0, 1'b0, WIdle);

    // Abort in the 7th busy cycle (step 1): idle next, no done.
    cyc4(1'b1, 1'b0, 1'b0, run_w(0));
    for (int i = 2; i <= 7; i++) cyc4(1'b0, 1'b0, 1'b0, run_w((i - 1) / 4));
    cyc4(1'b0, 1'b1, 1'b0, WIdle);
    cyc4(1'b0, 1'b0, 1'b0, WIdle);
    cyc4(1'b0, 1'b0, 1'b0, WIdle);

    // Start held: back-to-back sequences with only the done cycle between them.
    run15_4(1'b1);
    cyc4(1'b1, 1'b0, 1'b0, WDone);
    run15_4(1'b1);
    cyc4(1'b1, 1'b0, 1'b0, WDone);
    cyc4(1'b0, 1'b0, 1'b0, WIdle);

    // Stop on the completion edge suppresses done.
    run15_4(1'b0);
    cyc4(1'b0, 1'b1, 1'b0, WIdle);
    cyc4(1'b0, 1'b0, 1'b0, WIdle);

    // Start and stop together in idle: nothing starts.
    cyc4(1'b1, 1'b1, 1'b0, WIdle);
    cyc4(1'b1, 1'b1, 1'b0, WIdle);
    cyc4(1'b0, 1'b0, 1'b0, WIdle);

    // Reset during step 2, reset beating start, then a clean restart from step 0.
    cyc4(1'b1, 1'b0, 1'b0, run_w(0));
    for (int i = 1; i <= 8; i++) cyc4(1'b0, 1'b0, 1'b0, run_w(i / 4));
    cyc4(1'b0, 1'b0, 1'b1, WIdle);
    cyc4(1'b0, 1'b0, 1'b0, WIdle);
    cyc4(1'b1, 1'b0, 1'b1, WIdle);
    cyc4(1'b1, 1'b0, 1'b0, run_w(0));
    cyc4(1'b0, 1'b0, 1'b0, run_w(0));
    cyc4(1'b0, 1'b0, 1'b0, run_w(0));
    cyc4(1'b0, 1'b0, 1'b0, run_w(0));
    cyc4(1'b0, 1'b0, 1'b0, run_w(1));
    cyc4(1'b0, 1'b1, 1'b0, WIdle);
    cyc4(1'b0, 1'b0, 1'b0, WIdle);

    // HOLD=1: one step per cycle, done right after step 3.
    cyc1(1'b0, 1'b0, 1'b1, WIdle);
    cyc1(1'b0, 1'b0, 1'b1, WIdle);
    cyc1(1'b1, 1'b0, 1'b0, run_w(0));
    cyc1(1'b0, 1'b0, 1'b0, run_w(1));
    cyc1(1'b0, 1'b0, 1'b0, run_w(2));
    cyc1(1'b0, 1'b0, 1'b0, run_w(3));
    cyc1(1'b0, 1'b0, 1'b0, WDone);
    cyc1(1'b0, 1'b0, 1'b0, WIdle);
    cyc1(1'b1, 1'b0, 1'b0, run_w(0));
    cyc1(1'b0, 1'b0, 1'b0, run_w(1));
    cyc1(1'b0, 1'b1, 1'b0, WIdle);
    cyc1(1'b0, 1'b0, 1'b0, WIdle);

    @(negedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/stim_seq.md
STIM_SEQ -- requirements
Module: stim_seq

Interface
REQ-001 SHALL have parameter HOLD, default 20, meaning clock cycles each pattern step is held (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to run one pattern sequence; sampled on rising edge of clk.
REQ-005 SHALL have port stop  input  1  abort request; sampled on rising edge of clk.
REQ-006 SHALL have port in1  output  1  registered drive to downstream in1.
REQ-007 SHALL have port in2  output  1  registered drive to downstream in2.
REQ-008 SHALL have port in3  output  1  registered drive to downstream in3.
REQ-009 SHALL have port busy  output  1  high while a sequence runs.
REQ-010 SHALL have port done  output  1  one-cycle pulse on normal sequence completion.
REQ-011 SHALL have port step  output  2  index of the current pattern step; 0 when idle.

Function
REQ-012 SHALL implement states IDLE and RUN, plus a hold counter of width ceil(log2(HOLD+1)) bits, minimum 1 bit.
REQ-013 SHALL drive the step patterns {in3,in2,in1} as: step0=000, step1=001, step2=011, step3=111.
REQ-014 SHALL, in IDLE with start=1 and stop=0 at an edge: enter RUN, set step=0 and counter=0, set busy=1, drive 000.
REQ-015 SHALL, in RUN, increment the counter each cycle.
REQ-016 SHALL, when counter==HOLD-1 and step<3, clear the counter, increment step, and load the new step's pattern on the same edge.
REQ-017 SHALL, when counter==HOLD-1 and step==3, return to IDLE, set done=1 for exactly that next cycle, and set busy=0, step=0, outputs 000.
REQ-018 SHALL keep busy high for exactly 4*HOLD cycles per completed sequence, with each pattern visible for exactly HOLD cycles.
REQ-019 SHALL ignore start while in RUN, including on the completion edge; a new sequence begins only from IDLE.
REQ-020 SHALL, on stop=1 at any edge in RUN, go to IDLE with outputs 000, busy=0, step=0, counter=0, and no done pulse.
REQ-021 SHALL give stop priority over start when both are high in IDLE, so no sequence starts.
REQ-022 SHALL give stop priority over completion when both occur on the same edge, so no done pulse is produced.
REQ-023 SHALL, with HOLD=1, advance one step per cycle and keep busy high for exactly 4 cycles.
REQ-024 SHALL drive all outputs directly from flops, with no combinational path from any input to any output.
REQ-025 SHALL keep done low at all times except the single cycle defined in REQ-017.

Reset
REQ-026 SHALL, with rst=1 at an edge, force state IDLE, counter=0, step=0, in1=in2=in3=0, busy=0, done=0.
REQ-027 SHALL give rst priority over start and stop, and SHALL abort a running sequence with no done pulse.
REQ-028 SHALL, on the first edge after rst deasserts, honour start per REQ-014.

Verification
REQ-029 SHALL pass with HOLD=4, rst for 2 cycles, then start pulsed 1 cycle -> busy for 16 cycles; {in3,in2,in1}=000,001,011,111 for 4 cycles each; done high 1 cycle; then all outputs 0.
REQ-030 SHALL pass with HOLD=4, stop asserted in the 7th busy cycle (step=1) -> outputs 000, busy=0 on the next cycle, and done never asserted.
REQ-031 SHALL pass with HOLD=4, start held high continuously -> sequences run back-to-back separated by exactly 1 idle cycle (the done cycle), with start ignored during RUN.
REQ-032 SHALL pass with start and stop both high in IDLE -> busy stays 0 and outputs stay 000.
REQ-033 SHALL pass with HOLD=1 and start pulsed -> patterns 000,001,011,111 on 4 consecutive cycles, then done=1.
REQ-034 SHALL pass with HOLD=4, rst asserted 1 cycle during step=2 -> next cycle all outputs 0 and no done; a subsequent start restarts from step=0.
